// File: rtl/axis_cpu_divmod_pkg.sv
// Shared constants for the CPU divider: datapath width, FSM state encodings
// and the iteration-count helper.
package axis_cpu_divmod_pkg;

  localparam int AXIS_CPU_DW = 32;

  // Iteration counter must hold N = 32 for the single-bit-per-clock build.
  localparam int CNT_W = 6;

  localparam logic [1:0] AXIS_CPU_DIVMOD_IDLE = 2'd0;
  localparam logic [1:0] AXIS_CPU_DIVMOD_RUN  = 2'd1;
  localparam logic [1:0] AXIS_CPU_DIVMOD_DONE = 2'd2;

  // Number of clocks spent in RUN when retiring 'unroll' quotient bits per clock.
  function automatic logic [CNT_W-1:0] divmod_iters(input int unroll);
    return CNT_W'(AXIS_CPU_DW / unroll);
  endfunction

endpackage

// File: rtl/axis_cpu_divmod_if.sv
// Operand/result bundle between the ALU and the divider.
//
// Handshake: the ALU raises divmod_en with A/B stable for one edge; the
// divider accepts it on that edge whenever it is not busy (IDLE or DONE).
// divmod_vld then stays high with div_res/mod_res/div_by_zero stable until
// the ALU pulses divmod_ack or issues a new divmod_en (a new request wins
// over a simultaneous ack). Requests while busy=1 are dropped, not queued.
interface axis_cpu_divmod_if;
  import axis_cpu_divmod_pkg::*;

  logic [AXIS_CPU_DW-1:0] A;
  logic [AXIS_CPU_DW-1:0] B;
  logic                   divmod_en;
  logic                   divmod_ack;
  logic [AXIS_CPU_DW-1:0] div_res;
  logic [AXIS_CPU_DW-1:0] mod_res;
  logic                   div_by_zero;
  logic                   divmod_vld;
  logic                   busy;

  // ALU side.
  modport master (
    output A, B, divmod_en, divmod_ack,
    input  div_res, mod_res, div_by_zero, divmod_vld, busy
  );

  // Divider side.
  modport slave (
    input  A, B, divmod_en, divmod_ack,
    output div_res, mod_res, div_by_zero, divmod_vld, busy
  );
endinterface

// File: rtl/axis_cpu_divmod_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the resulting
// quotient bit into the LSB of Q' (q_o[0] is the retired quotient bit).
module divmod_step
  import axis_cpu_divmod_pkg::*;
(
  input  logic [AXIS_CPU_DW:0]   r_i,
  input  logic [AXIS_CPU_DW-1:0] q_i,
  input  logic [AXIS_CPU_DW-1:0] bd_i,
  output logic [AXIS_CPU_DW:0]   r_o,
  output logic [AXIS_CPU_DW-1:0] q_o
);

  // One guard bit above the 33-bit remainder so the compare never wraps.
  logic [AXIS_CPU_DW+1:0] t;
  logic                   fits;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    t    = {r_i, q_i[AXIS_CPU_DW-1]};
    fits = (t >= {2'b00, bd_i});
    r_o  = (AXIS_CPU_DW+1)'(fits ? (t - {2'b00, bd_i}) : t);
    q_o  = {q_i[AXIS_CPU_DW-2:0], fits};
  end

endmodule

// File: rtl/axis_cpu_divmod.sv
// Iterative unsigned 32-bit divider for the ALU's DIV/MOD instructions.
// One request yields quotient and remainder; UNROLL (1, 2, 4 or 8) restoring
// steps are chained combinationally so each RUN clock retires UNROLL bits.
// A zero divisor bypasses RUN and reports q=0, r=A with div_by_zero set.
module axis_cpu_divmod
  import axis_cpu_divmod_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_cpu_divmod_if.slave     dm,
  output logic [1:0]           dbg_state_o
);

  localparam logic [CNT_W-1:0] N_ITER = divmod_iters(UNROLL);
  localparam int               DW     = AXIS_CPU_DW;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    q_q, q_d;
  logic [DW:0]      r_q, r_d;
  logic [DW-1:0]    bd_q, bd_d;
  logic [DW-1:0]    div_res_q, div_res_d;
  logic [DW-1:0]    mod_res_q, mod_res_d;
  logic             dbz_q, dbz_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;

  // Step chain: element 0 is the registered state, element UNROLL is the
  // value after this clock's steps.
  logic [DW:0]   r_chain [UNROLL+1];
  logic [DW-1:0] q_chain [UNROLL+1];

  assign r_chain[0] = r_q;
  assign q_chain[0] = q_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    divmod_step u_step (
      .r_i  (r_chain[g]),
      .q_i  (q_chain[g]),
      .bd_i (bd_q),
      .r_o  (r_chain[g+1]),
      .q_o  (q_chain[g+1])
    );
  end

  // Next-state and datapath update: accept in IDLE/DONE, iterate in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    r_d       = r_q;
    bd_d      = bd_q;
    div_res_d = div_res_q;
    mod_res_d = mod_res_q;
    dbz_d     = dbz_q;
    vld_d     = vld_q;
    busy_d    = busy_q;

    case (state_q)
      AXIS_CPU_DIVMOD_IDLE, AXIS_CPU_DIVMOD_DONE: begin
        if (dm.divmod_en) begin
          if (dm.B != '0) begin
            state_d = AXIS_CPU_DIVMOD_RUN;
            q_d     = dm.A;
            r_d     = '0;
            bd_d    = dm.B;
            cnt_d   = N_ITER;
            busy_d  = 1'b1;
            vld_d   = 1'b0;
          end else begin
            // Zero divisor: answer immediately, result registers reload.
            state_d   = AXIS_CPU_DIVMOD_DONE;
            div_res_d = '0;
            mod_res_d = dm.A;
            dbz_d     = 1'b1;
            vld_d     = 1'b1;
          end
        end else if (state_q == AXIS_CPU_DIVMOD_DONE && dm.divmod_ack) begin
          state_d = AXIS_CPU_DIVMOD_IDLE;
          vld_d   = 1'b0;
        end
      end

      AXIS_CPU_DIVMOD_RUN: begin
        q_d   = q_chain[UNROLL];
        r_d   = r_chain[UNROLL];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d   = AXIS_CPU_DIVMOD_DONE;
          div_res_d = q_chain[UNROLL];
          mod_res_d = r_chain[UNROLL][DW-1:0];
          dbz_d     = 1'b0;
          vld_d     = 1'b1;
          busy_d    = 1'b0;
        end
      end

      default: begin
        state_d = AXIS_CPU_DIVMOD_IDLE;
        busy_d  = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= AXIS_CPU_DIVMOD_IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      bd_q      <= '0;
      div_res_q <= '0;
      mod_res_q <= '0;
      dbz_q     <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      r_q       <= r_d;
      bd_q      <= bd_d;
      div_res_q <= div_res_d;
      mod_res_q <= mod_res_d;
      dbz_q     <= dbz_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
    end
  end

  assign dm.div_res     = div_res_q;
  assign dm.mod_res     = mod_res_q;
  assign dm.div_by_zero = dbz_q;
  assign dm.divmod_vld  = vld_q;
  assign dm.busy        = busy_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_axis_cpu_divmod.sv
// Bench for axis_cpu_divmod: one UNROLL=1 and one UNROLL=4 instance share
// clock and reset. Directed cases plus random operands, all checked against
// plain '/' and '%' arithmetic.
module tb_axis_cpu_divmod;

  logic clk;
  logic rst;

  axis_cpu_divmod_if if0 ();
  axis_cpu_divmod_if if1 ();
  logic [1:0] st0, st1;

  axis_cpu_divmod #(.UNROLL(1)) u_dut1 (.clk(clk), .rst(rst), .dm(if0), .dbg_state_o(st0));
  axis_cpu_divmod #(.UNROLL(4)) u_dut4 (.clk(clk), .rst(rst), .dm(if1), .dbg_state_o(st1));

  // Per-instance drive/observe arrays so tasks can select an instance by index.
  logic [31:0] a_s [2];
  logic [31:0] b_s [2];
  logic        en_s [2];
  logic        ack_s [2];
  logic [31:0] q_s [2];
  logic [31:0] r_s [2];
  logic        dbz_s [2];
  logic        vld_s [2];
  logic        busy_s [2];

  assign if0.A = a_s[0];  assign if0.B = b_s[0];
  assign if0.divmod_en = en_s[0];  assign if0.divmod_ack = ack_s[0];
  assign if1.A = a_s[1];  assign if1.B = b_s[1];
  assign if1.divmod_en = en_s[1];  assign if1.divmod_ack = ack_s[1];
  assign q_s[0] = if0.div_res;  assign r_s[0] = if0.mod_res;
  assign dbz_s[0] = if0.div_by_zero;  assign vld_s[0] = if0.divmod_vld;
  assign busy_s[0] = if0.busy;
  assign q_s[1] = if1.div_res;  assign r_s[1] = if1.mod_res;
  assign dbz_s[1] = if1.div_by_zero;  assign vld_s[1] = if1.divmod_vld;
  assign busy_s[1] = if1.busy;

  int checks_n   = 0;
  int failures_n = 0;

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_n++;
    if (got !== exp) begin
      failures_n++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: quotient, remainder and zero flag from plain arithmetic.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {1'b1, 32'd0, a};
    return {1'b0, a / b, a % b};
  endfunction

  function automatic int lat_of(input int s, input logic [31:0] b);
    if (b == 32'd0) return 0;
    return (s == 0) ? 32 : 8;
  endfunction

  // Pulse divmod_en for one edge; returns at the negedge after the accepting edge.
  task automatic start(input int s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    a_s[s] = a; b_s[s] = b; en_s[s] = 1'b1;
    @(negedge clk);
    en_s[s] = 1'b0;
  endtask

  // Count edges until vld, bounded; busy must be high every cycle until then.
  task automatic wait_vld(input int s, input int exp_lat, input bit chk_busy);
    int n = 0;
    while (!vld_s[s] && n < 200) begin
      if (chk_busy) check("busy_run", 64'(busy_s[s]), 64'd1);
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("vld_set", 64'(vld_s[s]), 64'd1);
    check("busy_done", 64'(busy_s[s]), 64'd0);
  endtask

  task automatic check_res(input int s, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] m;
    m = model(a, b);
    check("div_res", 64'(q_s[s]), 64'(m[63:32]));
    check("mod_res", 64'(r_s[s]), 64'(m[31:0]));
    check("div_by_zero", 64'(dbz_s[s]), 64'(m[64]));
  endtask

  task automatic do_ack(input int s);
    ack_s[s] = 1'b1;
    @(negedge clk);
    ack_s[s] = 1'b0;
    check("vld_clear", 64'(vld_s[s]), 64'd0);
  endtask

  task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b);
    start(s, a, b);
    wait_vld(s, lat_of(s, b), b != 32'd0);
    check_res(s, a, b);
    do_ack(s);
  endtask

  function automatic logic [31:0] rand_b();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'd0;
    if (k <= 3) return 32'($urandom_range(1, 15));
    if (k == 4) return 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
    return $urandom;
  endfunction

  initial begin
    bit saw_vld;
    for (int s = 0; s < 2; s++) begin
      a_s[s] = '0; b_s[s] = '0; en_s[s] = 1'b0; ack_s[s] = 1'b0;
    end
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_vld", 64'(vld_s[s]), 64'd0);
      check("rst_busy", 64'(busy_s[s]), 64'd0);
      check("rst_dbz", 64'(dbz_s[s]), 64'd0);
      check("rst_div", 64'(q_s[s]), 64'd0);
      check("rst_mod", 64'(r_s[s]), 64'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 100/7 with a five-cycle hold before acknowledging.
    start(0, 32'd100, 32'd7);
    wait_vld(0, 32, 1'b1);
    check_res(0, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_vld", 64'(vld_s[0]), 64'd1);
      check("hold_div", 64'(q_s[0]), 64'd14);
      check("hold_mod", 64'(r_s[0]), 64'd2);
    end
    do_ack(0);

    // Full-range corners.
    run_op(0, 32'hFFFF_FFFF, 32'd1);
    run_op(0, 32'd5, 32'hFFFF_FFFF);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(0, 32'd0, 32'd3);

    // Zero divisor, then a second zero-divisor request while still valid.
    start(0, 32'h1234, 32'd0);
    wait_vld(0, 0, 1'b0);
    check_res(0, 32'h1234, 32'd0);
    a_s[0] = 32'h55; b_s[0] = 32'd0; en_s[0] = 1'b1;
    @(negedge clk);
    en_s[0] = 1'b0;
    check("dbz_rearm_vld", 64'(vld_s[0]), 64'd1);
    check_res(0, 32'h55, 32'd0);
    do_ack(0);

    // Request while busy is dropped; the running 100/7 completes unchanged.
    start(0, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    a_s[0] = 32'd9; b_s[0] = 32'd2; en_s[0] = 1'b1;
    @(negedge clk);
    en_s[0] = 1'b0;
    wait_vld(0, 21, 1'b1);
    check_res(0, 32'd100, 32'd7);

    // New request together with ack in DONE: new run wins, old results held meanwhile.
    a_s[0] = 32'd9; b_s[0] = 32'd2; en_s[0] = 1'b1; ack_s[0] = 1'b1;
    @(negedge clk);
    en_s[0] = 1'b0; ack_s[0] = 1'b0;
    check("restart_vld", 64'(vld_s[0]), 64'd0);
    check("restart_held_div", 64'(q_s[0]), 64'd14);
    wait_vld(0, 32, 1'b1);
    check_res(0, 32'd9, 32'd2);
    do_ack(0);

    // Asynchronous reset mid-run.
    start(0, 32'd100, 32'd7);
    start(1, 32'd77, 32'd5);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_vld", 64'(vld_s[0]), 64'd0);
    check("arst_busy", 64'(busy_s[0]), 64'd0);
    check("arst_busy4", 64'(busy_s[1]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw_vld = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vld_s[0] || vld_s[1] || busy_s[0]) saw_vld = 1'b1;
    end
    check("arst_no_stale", 64'(saw_vld), 64'd0);
    run_op(0, 32'd100, 32'd7);

    // UNROLL=4 directed.
    run_op(1, 32'd1000000, 32'd3);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(1, 32'h1234, 32'd0);

    // Random cross-check on both builds.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      run_op(0, a, rand_b());
    end
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      run_op(1, a, rand_b());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
    $finish;
  end

endmodule
